divider_unit: RTL and testbench

DIVIDER_UNIT -- requirements
Module: divider_unit

---
 rtl/divider_unit.sv | 148 ++++++++++++++
 tb/tb_divider_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// Sequential 32-bit integer divider: DIV/DIVU/REM/REMU via radix-2 restoring division.
// Optional DIVIDER_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iterative phase.
module divider_unit (
  input  logic        CLK,
  input  logic        nrst,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        div_valid,
  input  logic [1:0]  div_op,
  output logic        div_running,
  output logic [31:0] DIVout
);

  typedef enum logic [1:0] {
    S_RESET    = 2'd0,
    S_WAIT     = 2'd1,
    S_DIVIDING = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t      div_state, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;      // raw dividend, then magnitude / quotient shift register
  logic [31:0] b_q, b_d;      // raw divisor, then magnitude
  logic [31:0] rem_q, rem_d;
  logic [1:0]  op_q, op_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] dout_q, dout_d;

  // one restoring step on the current partial remainder
  logic [32:0] rem_sh, diff;
  logic        fits;
  logic [31:0] step_quo, step_rem, quo_fix, rem_fix, result;
  logic        op_signed;

  always_comb begin
    rem_sh   = {rem_q, a_q[31]};
    diff     = rem_sh - {1'b0, b_q};
    fits     = ~diff[32];
    step_rem = fits ? diff[31:0] : rem_sh[31:0];
    step_quo = {a_q[30:0], fits};
    quo_fix  = negq_q ? (32'd0 - step_quo) : step_quo;
    rem_fix  = negr_q ? (32'd0 - step_rem) : step_rem;
    result   = op_q[1] ? rem_fix : quo_fix;
  end

  assign op_signed = ~op_q[0];

`ifdef DIVIDER_EARLY_OUT_EN
  logic        fast_zero, fast_ovf, fast_hit;
  logic [31:0] fast_res;

  always_comb begin
    fast_zero = (opB == 32'd0);
    fast_ovf  = ~div_op[0] && (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF);
    fast_hit  = fast_zero | fast_ovf;
    if (fast_zero) fast_res = div_op[1] ? opA : 32'hFFFF_FFFF;
    else           fast_res = div_op[1] ? 32'd0 : 32'h8000_0000;
  end
`endif

  always_comb begin
    state_d = div_state;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dout_d  = dout_q;
    case (div_state)
      S_RESET: state_d = S_WAIT;
      S_WAIT: begin
        if (div_valid) begin
`ifdef DIVIDER_EARLY_OUT_EN
          if (fast_hit) begin
            dout_d  = fast_res;
            state_d = S_DONE;
          end else begin
            a_d     = opA;
            b_d     = opB;
            op_d    = div_op;
            cnt_d   = 6'd0;
            state_d = S_DIVIDING;
          end
`else
          a_d     = opA;
          b_d     = opB;
          op_d    = div_op;
          cnt_d   = 6'd0;
          state_d = S_DIVIDING;
`endif
        end
      end
      S_DIVIDING: begin
        if (cnt_q == 6'd0) begin
          // first cycle turns operands into magnitudes; the next 32 produce quotient bits
          a_d    = (op_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
          b_d    = (op_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
          rem_d  = 32'd0;
          negq_d = op_signed && (a_q[31] ^ b_q[31]) && (b_q != 32'd0);
          negr_d = op_signed && a_q[31];
          cnt_d  = 6'd1;
        end else begin
          a_d   = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd32) begin
            dout_d  = result;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_WAIT;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      div_state <= S_RESET;
      cnt_q     <= 6'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rem_q     <= 32'd0;
      op_q      <= 2'd0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      dout_q    <= 32'd0;
    end else begin
      div_state <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      op_q      <= op_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      dout_q    <= dout_d;
    end
  end

  assign div_running = (div_state == S_DIVIDING) || ((div_state == S_WAIT) && div_valid);
  assign DIVout      = dout_q;

endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit: results, latency, held outputs and reset abort.
module tb_divider_unit;

  logic        CLK = 1'b0;
  logic        nrst;
  logic [31:0] opA, opB;
  logic        div_valid;
  logic [1:0]  div_op;
  logic        div_running;
  logic [31:0] DIVout;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_out;

`ifdef DIVIDER_EARLY_OUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif

  divider_unit dut (
    .CLK         (CLK),
    .nrst        (nrst),
    .opA         (opA),
    .opB         (opB),
    .div_valid   (div_valid),
    .div_op      (div_op),
    .div_running (div_running),
    .DIVout      (DIVout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents an op with div_valid held; returns with the DUT in DONE.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] exp, input int lat, input string tag);
    int cyc;
    opA = a; opB = b; div_op = op; div_valid = 1'b1;
    if (dut.div_state == 2'd3) begin
      tick();
      chk({tag, " hold"}, DIVout, last_out);
    end
    #1;
    chk({tag, " wait"}, {30'd0, dut.div_state}, 32'd1);
    chk({tag, " run"}, {31'd0, div_running}, 32'd1);
    cyc = 0;
    while (dut.div_state != 2'd3 && cyc < 80) begin
      tick();
      cyc++;
      if (cyc == 1 && lat > 1) chk({tag, " run_div"}, {31'd0, div_running}, 32'd1);
    end
    chk({tag, " lat"}, cyc, lat);
    chk({tag, " res"}, DIVout, exp);
    chk({tag, " run_done"}, {31'd0, div_running}, 32'd0);
    last_out = exp;
  endtask

  initial begin
    bit seen_done;
    nrst = 1'b0; div_valid = 1'b1; opA = 32'd0; opB = 32'd0; div_op = 2'd0;
    last_out = 32'd0;
    repeat (3) tick();
    chk("rst state", {30'd0, dut.div_state}, 32'd0);
    chk("rst out", DIVout, 32'd0);
    chk("rst run", {31'd0, div_running}, 32'd0);

    div_valid = 1'b0;
    nrst = 1'b1;
    tick();
    chk("rel wait", {30'd0, dut.div_state}, 32'd1);
    chk("rel run", {31'd0, div_running}, 32'd0);
    tick();
    chk("idle wait", {30'd0, dut.div_state}, 32'd1);

    issue(32'hC0E19800, 32'hEEE19000, 2'd0, 32'h00000003, 34, "v1 DIV");
    issue(32'hC0E19800, 32'hEEE19000, 2'd1, 32'h00000000, 34, "v1 DIVU");
    issue(32'hC0E19800, 32'hEEE19000, 2'd2, 32'hF43CE800, 34, "v1 REM");
    issue(32'hC0E19800, 32'hEEE19000, 2'd3, 32'hC0E19800, 34, "v1 REMU");

    issue(32'd100, 32'hFFFFFFFA, 2'd0, 32'hFFFFFFF0, 34, "v2 DIV");
    issue(32'd100, 32'hFFFFFFFA, 2'd2, 32'h00000004, 34, "v2 REM");
    issue(32'd100, 32'hFFFFFFFA, 2'd1, 32'h00000000, 34, "v2 DIVU");
    issue(32'd100, 32'hFFFFFFFA, 2'd3, 32'h00000064, 34, "v2 REMU");

    issue(32'd7, 32'd0, 2'd0, 32'hFFFFFFFF, ZLAT, "z DIV");
    issue(32'd7, 32'd0, 2'd1, 32'hFFFFFFFF, ZLAT, "z DIVU");
    issue(32'd7, 32'd0, 2'd2, 32'h00000007, ZLAT, "z REM");
    issue(32'd7, 32'd0, 2'd3, 32'h00000007, ZLAT, "z REMU");

    issue(32'h80000000, 32'hFFFFFFFF, 2'd0, 32'h80000000, ZLAT, "ovf DIV");
    issue(32'h80000000, 32'hFFFFFFFF, 2'd2, 32'h00000000, ZLAT, "ovf REM");
    issue(32'h80000000, 32'hFFFFFFFF, 2'd1, 32'h00000000, 34, "ovf DIVU");
    issue(32'h80000000, 32'hFFFFFFFF, 2'd3, 32'h80000000, 34, "ovf REMU");

    div_valid = 1'b0;
    tick();
    chk("drop wait", {30'd0, dut.div_state}, 32'd1);
    chk("drop run", {31'd0, div_running}, 32'd0);
    chk("drop hold", DIVout, 32'h80000000);

    // abort a running op on cycle 10 of DIVIDING
    opA = 32'd1000; opB = 32'd7; div_op = 2'd0; div_valid = 1'b1;
    repeat (10) tick();
    chk("mid dividing", {30'd0, dut.div_state}, 32'd2);
    nrst = 1'b0; div_valid = 1'b0;
    tick();
    chk("mid rst state", {30'd0, dut.div_state}, 32'd0);
    chk("mid rst out", DIVout, 32'd0);
    chk("mid rst run", {31'd0, div_running}, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      tick();
      if (dut.div_state == 2'd3) seen_done = 1'b1;
    end
    chk("mid no done", {31'd0, seen_done}, 32'd0);
    nrst = 1'b1;
    tick();
    chk("mid rel wait", {30'd0, dut.div_state}, 32'd1);
    issue(32'd25, 32'd4, 2'd0, 32'h00000006, 34, "post DIV");

    div_valid = 1'b0;
    tick();
    chk("end wait", {30'd0, dut.div_state}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
